spike_rate_decoder: RTL and testbench

// - Downstream consumer of a neuron's spike_out: counts spike rising edges over a fixed window of
//   clk cycles and publishes the count as a rate word through a valid/ready handshake.
// - Sits between the neuron output and any readout or host logic. Turns a 1-bit spike train into a
//   CNT_W-bit rate sample, once per window.

---
 rtl/spike_rate_decoder.sv | 199 +++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising edges of spike_in over WINDOW-cycle windows and publishes a
// saturated CNT_W-bit rate over valid/ready. Define SPIKE_BURST_DETECT_EN to build the burst flag.

module spike_rate_decoder #(
  parameter int WINDOW    = 1000,
  parameter int CNT_W     = 8,
  parameter int BURST_GAP = 4,
  parameter int BURST_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spike_in,
  input  logic             rate_ready,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overrun,
  output logic             burst
);

  localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [WIN_W-1:0] win_cnt_r, win_cnt_s;
  logic [CNT_W-1:0] spike_cnt_r, spike_cnt_s;
  logic [CNT_W-1:0] rate_out_r, rate_out_s;
  logic             spike_prev_r;
  logic             rate_valid_r, rate_valid_s;
  logic             overrun_r, overrun_s;
  logic             edge_s, win_end_s, xfer_s;

  assign edge_s = spike_in & ~spike_prev_r;
  assign xfer_s = rate_valid_r & rate_ready;

  // Next-state, window counting and sample capture
  always_comb begin
    state_s     = state_r;
    win_cnt_s   = win_cnt_r;
    spike_cnt_s = spike_cnt_r;
    rate_out_s  = rate_out_r;
    win_end_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        win_cnt_s   = '0;
        spike_cnt_s = '0;
        if (en) begin
          state_s = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          // abandoning a window throws away the partial count
          state_s     = ST_IDLE;
          win_cnt_s   = '0;
          spike_cnt_s = '0;
        end else if (win_cnt_r == WIN_LAST) begin
          win_end_s   = 1'b1;
          rate_out_s  = sat_inc(spike_cnt_r, edge_s);
          win_cnt_s   = '0;
          spike_cnt_s = '0;
        end else begin
          win_cnt_s   = win_cnt_r + WIN_W'(1);
          spike_cnt_s = sat_inc(spike_cnt_r, edge_s);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        win_cnt_s   = '0;
        spike_cnt_s = '0;
      end
    endcase
  end

  // Handshake valid and sticky overrun; a new overrun beats a simultaneous clear
  always_comb begin
    rate_valid_s = rate_valid_r;
    overrun_s    = overrun_r;
    if (win_end_s) begin
      rate_valid_s = 1'b1;
    end else if (xfer_s) begin
      rate_valid_s = 1'b0;
    end else begin
      rate_valid_s = rate_valid_r;
    end
    if (win_end_s && rate_valid_r && !xfer_s) begin
      overrun_s = 1'b1;
    end else if (clr_overrun) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      win_cnt_r    <= '0;
      spike_cnt_r  <= '0;
      rate_out_r   <= '0;
      spike_prev_r <= 1'b0;
      rate_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      win_cnt_r    <= win_cnt_s;
      spike_cnt_r  <= spike_cnt_s;
      rate_out_r   <= rate_out_s;
      spike_prev_r <= spike_in;
      rate_valid_r <= rate_valid_s;
      overrun_r    <= overrun_s;
    end
  end

  assign rate_out   = rate_out_r;
  assign rate_valid = rate_valid_r;
  assign overrun    = overrun_r;

`ifdef SPIKE_BURST_DETECT_EN
  localparam int               GAP_W   = $clog2(BURST_GAP + 2);
  localparam int               RUN_W   = $clog2(BURST_LEN + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(BURST_GAP);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(BURST_GAP + 1);
  localparam logic [RUN_W-1:0] RUN_LEN = RUN_W'(BURST_LEN);

  logic [GAP_W-1:0] gap_r, gap_s;
  logic [RUN_W-1:0] run_r, run_s;
  logic             burst_r, burst_s;

  // Gap since last edge and current run length; flag fires once when a run reaches RUN_LEN
  always_comb begin
    gap_s   = gap_r;
    run_s   = run_r;
    burst_s = 1'b0;
    if (state_r == ST_COUNT) begin
      if (edge_s) begin
        gap_s = GAP_W'(1);
        if (gap_r <= GAP_LIM) begin
          if (run_r < RUN_LEN) begin
            run_s   = run_r + RUN_W'(1);
            burst_s = (run_r == (RUN_LEN - RUN_W'(1)));
          end else begin
            run_s   = run_r;
            burst_s = 1'b0;
          end
        end else begin
          run_s   = RUN_W'(1);
          burst_s = (RUN_LEN == RUN_W'(1));
        end
      end else if (gap_r != GAP_SAT) begin
        gap_s = gap_r + GAP_W'(1);
      end else begin
        gap_s = gap_r;
      end
    end else begin
      gap_s = '0;
      run_s = '0;
    end
  end

  // Burst tracking registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_r   <= '0;
      run_r   <= '0;
      burst_r <= 1'b0;
    end else begin
      gap_r   <= gap_s;
      run_r   <= run_s;
      burst_r <= burst_s;
    end
  end

  assign burst = burst_r;
`else
  assign burst = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with WINDOW=16, CNT_W=3; burst cases need
// SPIKE_BURST_DETECT_EN, otherwise burst is checked to stay 0.

module tb_spike_rate_decoder;

  logic       clk;
  logic       reset;
  logic       en;
  logic       spike_in;
  logic       rate_ready;
  logic       clr_overrun;
  logic [2:0] rate_out;
  logic       rate_valid;
  logic       overrun;
  logic       burst;

  int checks = 0;
  int errors = 0;
`ifdef SPIKE_BURST_DETECT_EN
  bit burst_watch = 1'b0;
`endif

  spike_rate_decoder #(
    .WINDOW(16),
    .CNT_W(3),
    .BURST_GAP(4),
    .BURST_LEN(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .spike_in(spike_in),
    .rate_ready(rate_ready),
    .clr_overrun(clr_overrun),
    .rate_out(rate_out),
    .rate_valid(rate_valid),
    .overrun(overrun),
    .burst(burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int r, input int v, input int o);
    check({tag, ".rate"}, 32'(rate_out), r);
    check({tag, ".valid"}, 32'(rate_valid), v);
    check({tag, ".overrun"}, 32'(overrun), o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full window: pat[k] is spike_in in window cycle k; bexp[k] is burst seen during cycle k
  task automatic run_window(input logic [15:0] pat, input logic [15:0] bexp, input bit lat,
                            input bit clr_last, input bit rdy_last);
    for (int k = 0; k < 16; k++) begin
      spike_in    = pat[k];
      clr_overrun = clr_last && (k == 15);
      if (rdy_last) rate_ready = (k == 15);
`ifdef SPIKE_BURST_DETECT_EN
      if (burst_watch) check("burst", 32'(burst), 32'(bexp[k]));
`else
      check("burst", 32'(burst), 32'(bexp[k]));
`endif
      if (lat && (k == 15)) check("latency", 32'(rate_valid), 32'd0);
      step();
    end
    clr_overrun = 1'b0;
    if (rdy_last) rate_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; clr_overrun = 1'b0;
    step();
    step();
    expect_out("reset", 0, 0, 0);
    check("reset.burst", 32'(burst), 32'd0);
    reset = 1'b0;
    step();

    // five isolated spikes, consumer always ready
    rate_ready = 1'b1;
    en = 1'b1;
    step();
    run_window(16'h0155, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_out("five", 5, 1, 0);
    en = 1'b0;
    step();
    expect_out("five_xfer", 5, 0, 0);

    // spike already high when en rises is not an edge
    spike_in = 1'b1;
    step();
    en = 1'b1;
    step();
    run_window(16'h0103, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("prehigh", 1, 1, 0);
    en = 1'b0; spike_in = 1'b0;
    step();

    // held-high spike counts once, plus an edge on the final cycle
    en = 1'b1;
    step();
    run_window(16'h83FF, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("held", 2, 1, 0);
    en = 1'b0; spike_in = 1'b0;
    step();

    // alternating spikes saturate at 7, back-to-back windows
    en = 1'b1;
    step();
    run_window(16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("sat_even", 7, 1, 0);
    run_window(16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("sat_odd", 7, 1, 0);
    en = 1'b0; spike_in = 1'b0;
    step();
    check("sat.valid_clr", 32'(rate_valid), 32'd0);

    // consumer stalled over two windows; clear in the overwrite cycle loses to the set
    rate_ready = 1'b0;
    en = 1'b1;
    step();
    run_window(16'h0111, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("ovr_first", 3, 1, 0);
    run_window(16'h1111, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_out("ovr_second", 4, 1, 1);
    en = 1'b0;
    step();
    expect_out("ovr_idle", 4, 1, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    expect_out("ovr_clr", 4, 1, 0);

    // window end coincides with transfer: new sample, valid held, no overrun
    en = 1'b1;
    step();
    run_window(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("coincide", 1, 1, 0);
    rate_ready = 1'b1;
    en = 1'b0;
    step();
    check("coincide.xfer", 32'(rate_valid), 32'd0);

    // en dropped at cycle 8 after 3 edges discards the partial window
    en = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      spike_in = (k == 0) || (k == 2) || (k == 4);
      step();
    end
    en = 1'b0; spike_in = 1'b0;
    step();
    expect_out("abort", 1, 0, 0);
    en = 1'b1;
    step();
    run_window(16'h0201, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("abort_next", 2, 1, 0);
    en = 1'b0;
    step();

`ifdef SPIKE_BURST_DETECT_EN
    burst_watch = 1'b1;
    en = 1'b1;
    step();
    run_window(16'h0049, 16'h0080, 1'b0, 1'b0, 1'b0);
    check("burst.rate", 32'(rate_out), 32'd3);
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    run_window(16'h1041, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("noburst.rate", 32'(rate_out), 32'd3);
    en = 1'b0;
    step();
    burst_watch = 1'b0;
`endif

    // async reset mid-window with valid and overrun set
    rate_ready = 1'b0;
    en = 1'b1;
    step();
    run_window(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_window(16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("pre_reset", 1, 1, 1);
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    step();
    #2 reset = 1'b1;
    en = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0);
    check("async_reset.burst", 32'(burst), 32'd0);
    step();
    #2 reset = 1'b0;
    step();
    en = 1'b1;
    step();
    run_window(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("after_reset", 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
